// File: rtl/reg_file_arb_if.sv
// Requester-side bus of the arbitrated register file: two packed requester lanes plus shared read return.
// The optional lock lane exists only when REG_ARB_LOCK_EN is defined.
interface reg_file_arb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [1:0]          req;
    logic [1:0]          we;
    logic [2*ADDR_W-1:0] addr_in;
    logic [2*DATA_W-1:0] wdata_in;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata_out;
`ifdef REG_ARB_LOCK_EN
    logic [1:0]          lock;
`endif

    modport master (
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        output req, we, addr_in, wdata_in,
        input  gnt, rvalid, rdata_out
    );

    modport slave (
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        input  req, we, addr_in, wdata_in,
        output gnt, rvalid, rdata_out
    );
endinterface

// File: rtl/reg_file_arb.sv
// Two-requester round-robin arbiter in front of a NUM_REGS x DATA_W register file.
// Define REG_ARB_LOCK_EN to add the per-requester grant-hold (lock) behaviour.
module reg_file_arb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic            reset,
    input  logic            clock,
    reg_file_arb_if.slave   bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {PRI_0 = 1'b0, PRI_1 = 1'b1} pri_t;

    pri_t              pri_reg, pri_next;
    logic [DATA_W-1:0] mem_reg [NUM_REGS];
    logic [1:0]        rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [1:0]        gnt;
    logic              sel;
    logic              commit;
    logic              wr_en;
    logic [ADDR_W-1:0] addr_req  [2];
    logic [DATA_W-1:0] wdata_req [2];

`ifdef REG_ARB_LOCK_EN
    logic owner_valid_reg, owner_valid_next;
    logic owner_reg, owner_next;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign addr_req[gi]  = bus.addr_in[gi*ADDR_W +: ADDR_W];
            assign wdata_req[gi] = bus.wdata_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Grant is purely combinational so a sole requester is served in the same cycle.
    always_comb begin
        gnt = 2'b00;
`ifdef REG_ARB_LOCK_EN
        if (owner_valid_reg && bus.req[owner_reg])
            gnt[owner_reg] = 1'b1;
        else
`endif
        begin
            case (bus.req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (pri_reg == PRI_0) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign sel    = gnt[1];
    assign commit = |gnt;

    always_comb begin
        pri_next    = pri_reg;
        rvalid_next = 2'b00;
        rdata_next  = rdata_reg;
        wr_en       = 1'b0;
        if (commit) begin
            pri_next = sel ? PRI_0 : PRI_1;
            if (bus.we[sel]) begin
                wr_en = 1'b1;
            end else begin
                rvalid_next[sel] = 1'b1;
                rdata_next       = mem_reg[addr_req[sel]];
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    // An owner that drops req loses ownership at that edge even without a commit.
    always_comb begin
        owner_valid_next = owner_valid_reg;
        owner_next       = owner_reg;
        if (owner_valid_reg && !bus.req[owner_reg])
            owner_valid_next = 1'b0;
        if (commit) begin
            if (bus.lock[sel]) begin
                owner_valid_next = 1'b1;
                owner_next       = sel;
            end else if (owner_valid_reg && owner_reg == sel) begin
                owner_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_valid_reg <= 1'b0;
            owner_reg       <= 1'b0;
        end else begin
            owner_valid_reg <= owner_valid_next;
            owner_reg       <= owner_next;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem_reg[i] <= '0;
            pri_reg    <= PRI_0;
            rvalid_reg <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            if (wr_en)
                mem_reg[addr_req[sel]] <= wdata_req[sel];
            pri_reg    <= pri_next;
            rvalid_reg <= rvalid_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rvalid_reg;
    assign bus.rdata_out = rdata_reg;
endmodule
